usb_tx_arbiter: RTL and testbench

USB_TX_ARBITER -- requirements
Module: usb_tx_arbiter

---
 rtl/usb_arb_pkg.sv | 27 ++
 rtl/usb_tx_arbiter_if.sv | 27 ++
 rtl/usb_rr_pick.sv | 28 ++
 rtl/usb_tx_arbiter.sv | 139 +++++++++++++
 tb/tb_usb_tx_arbiter.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/usb_arb_pkg.sv
// Shared types and constants for the USB transmit arbiter.
// Holds the FSM encoding, the output-stage payload and the round-robin slot helper.
package usb_arb_pkg;

  localparam int unsigned MAX_REQ       = 4;
  localparam int unsigned OWNER_W       = 2;
  localparam int unsigned BURST_W       = 8;
  localparam int unsigned MAX_BURST_DEF = 64;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic       valid;
    logic [7:0] data;
  } send_beat_t;

  // Requester index visited k steps after last_owner, wrapping at n.
  function automatic int unsigned rr_slot(input logic [OWNER_W-1:0] last_owner,
                                          input int unsigned k,
                                          input int unsigned n);
    return (32'(last_owner) + k) % n;
  endfunction

endpackage

// File: rtl/usb_tx_arbiter_if.sv
// Byte-stream requester bus and device send channel of the USB transmit arbiter.
// master = test sources / device side, slave = arbiter.
interface usb_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 2
);

  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           send_data;
  logic                 send_valid;
  logic                 send_ready;
  logic [NUM_REQ-1:0]   grant;
  logic                 busy;

  modport master (
    output req_data, req_valid, req_last, send_ready,
    input  req_ready, send_data, send_valid, grant, busy
  );

  modport slave (
    input  req_data, req_valid, req_last, send_ready,
    output req_ready, send_data, send_valid, grant, busy
  );

endinterface

// File: rtl/usb_rr_pick.sv
// Combinational round-robin picker: first set request after last_owner, wrapping.
// Returns a one-hot winner, all zero when nothing is requesting.
module usb_rr_pick
  import usb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OWNER_W-1:0] last_owner,
  output logic [NUM_REQ-1:0] winner
);

  always_comb begin
    logic found;
    winner = '0;
    found  = 1'b0;
    // k = NUM_REQ lands back on last_owner, so it only wins when alone.
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] && (i == rr_slot(last_owner, k, NUM_REQ))) begin
          winner[i] = 1'b1;
          found     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/usb_tx_arbiter.sv
// Round-robin arbiter merging NUM_REQ byte streams onto one device send channel.
// Grants whole packets, capped at MAX_BURST bytes, through a single output register.
module usb_tx_arbiter
  import usb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input logic             clk,
  input logic             rst,
  input logic             usb_rstn,
  usb_tx_arbiter_if.slave bus
);

  arb_state_t           state_q, state_d;
  logic [OWNER_W-1:0]   owner_q, owner_d;
  logic [OWNER_W-1:0]   last_owner_q, last_owner_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [BURST_W-1:0]   burst_q, burst_d;
  send_beat_t           beat_q, beat_d;
  logic                 busy_q, busy_d;

  logic [NUM_REQ-1:0]   pick;
  logic [OWNER_W-1:0]   pick_idx;
  logic                 owner_valid;
  logic                 owner_last;
  logic [7:0]           owner_data;
  logic                 slot_free;
  logic [NUM_REQ-1:0]   ready_c;

  usb_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req        (bus.req_valid),
    .last_owner (last_owner_q),
    .winner     (pick)
  );

  // Winner index and the current owner's byte lane.
  always_comb begin
    pick_idx    = '0;
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_data  = 8'h00;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) begin
        pick_idx = OWNER_W'(i);
      end
      if (owner_q == OWNER_W'(i)) begin
        owner_valid = bus.req_valid[i];
        owner_last  = bus.req_last[i];
        owner_data  = bus.req_data[8*i +: 8];
      end
    end
  end

  assign slot_free = ~beat_q.valid | bus.send_ready;

  // Next-state, grant bookkeeping and output stage.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    grant_d      = grant_q;
    burst_d      = burst_q;
    beat_d       = beat_q;
    ready_c      = '0;

    if (beat_q.valid && bus.send_ready) begin
      beat_d.valid = 1'b0;
    end

    if (!usb_rstn) begin
      // Link down: drop everything except the round-robin history.
      state_d      = ST_IDLE;
      grant_d      = '0;
      burst_d      = '0;
      beat_d.valid = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|pick) begin
            state_d = ST_GRANT;
            owner_d = pick_idx;
            grant_d = pick;
            burst_d = '0;
          end
        end
        ST_GRANT: begin
          ready_c = grant_q & {NUM_REQ{slot_free}};
          if (owner_valid && slot_free) begin
            beat_d.valid = 1'b1;
            beat_d.data  = owner_data;
            burst_d      = burst_q + BURST_W'(1);
            if (owner_last || (burst_q == BURST_W'(MAX_BURST - 1))) begin
              state_d      = ST_IDLE;
              grant_d      = '0;
              burst_d      = '0;
              last_owner_d = owner_q;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      endcase
    end
  end

  assign busy_d = (state_d == ST_GRANT) | beat_d.valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_owner_q <= OWNER_W'(NUM_REQ - 1);
      grant_q      <= '0;
      burst_q      <= '0;
      beat_q       <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      grant_q      <= grant_d;
      burst_q      <= burst_d;
      beat_q       <= beat_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.req_ready  = ready_c;
  assign bus.send_data  = beat_q.data;
  assign bus.send_valid = beat_q.valid;
  assign bus.grant      = grant_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Directed bench for usb_tx_arbiter (NUM_REQ=2, MAX_BURST=4).
// Sources feed from per-requester queues; the send channel is logged and compared.
module tb_usb_tx_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic usb_rstn;

  usb_tx_arbiter_if #(.NUM_REQ(2)) bus ();

  usb_tx_arbiter #(
    .NUM_REQ   (2),
    .MAX_BURST (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .usb_rstn (usb_rstn),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [8:0]  q0[$];
  logic [8:0]  q1[$];
  logic [7:0]  rx[$];
  logic [7:0]  ex[$];
  logic [1:0]  glog[$];
  logic [1:0]  gprev = 2'b00;
  logic [1:0]  rdy_seen = 2'b00;
  logic        sr = 1'b1;
  logic        link = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic add(input int r, input logic [7:0] d, input logic l);
    if (r == 0) q0.push_back({l, d});
    else        q1.push_back({l, d});
  endtask

  // One clock: drive at negedge, capture handshakes, advance at next negedge.
  task automatic step();
    logic [1:0] acc;
    logic       snd;
    logic [7:0] sd;
    bus.req_valid  = 2'b00;
    bus.req_last   = 2'b00;
    bus.req_data   = 16'h0000;
    if (q0.size() > 0) begin
      bus.req_valid[0]  = 1'b1;
      bus.req_last[0]   = q0[0][8];
      bus.req_data[7:0] = q0[0][7:0];
    end
    if (q1.size() > 0) begin
      bus.req_valid[1]   = 1'b1;
      bus.req_last[1]    = q1[0][8];
      bus.req_data[15:8] = q1[0][7:0];
    end
    bus.send_ready = sr;
    usb_rstn       = link;
    #1;
    rdy_seen = bus.req_ready;
    acc      = bus.req_valid & bus.req_ready;
    snd      = bus.send_valid & bus.send_ready;
    sd       = bus.send_data;
    if (bus.grant != 2'b00 && bus.grant != gprev) glog.push_back(bus.grant);
    gprev = bus.grant;
    @(negedge clk);
    if (acc[0]) void'(q0.pop_front());
    if (acc[1]) void'(q1.pop_front());
    if (snd) rx.push_back(sd);
  endtask

  task automatic run_until(input int n, input string tag);
    int cnt = 0;
    while (rx.size() < n && cnt < 200) begin
      step();
      cnt++;
    end
    check(tag, 32'(rx.size()), 32'(n));
  endtask

  task automatic cmp_rx(input string tag);
    for (int i = 0; i < ex.size(); i++) begin
      check($sformatf("%s[%0d]", tag, i), (i < rx.size()) ? 32'(rx[i]) : 32'hDEAD, 32'(ex[i]));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q0.delete(); q1.delete(); rx.delete(); ex.delete(); glog.delete();
    gprev = 2'b00; sr = 1'b1; link = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    usb_rstn       = 1'b1;
    bus.req_valid  = 2'b00;
    bus.req_last   = 2'b00;
    bus.req_data   = 16'h0000;
    bus.send_ready = 1'b1;
    @(negedge clk);
    check("rst_grant", 32'(bus.grant), 32'h0);
    check("rst_valid", 32'(bus.send_valid), 32'h0);
    check("rst_data", 32'(bus.send_data), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_ready", 32'(bus.req_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Single 3-byte packet, cycle-exact latency.
    add(0, 8'h01, 1'b0); add(0, 8'h02, 1'b0); add(0, 8'h03, 1'b1);
    step();
    check("a_grant", 32'(bus.grant), 32'h1);
    check("a_sv0", 32'(bus.send_valid), 32'h0);
    check("a_busy", 32'(bus.busy), 32'h1);
    step();
    check("a_sv1", 32'(bus.send_valid), 32'h1);
    check("a_sd1", 32'(bus.send_data), 32'h01);
    step();
    check("a_sd2", 32'(bus.send_data), 32'h02);
    step();
    check("a_sd3", 32'(bus.send_data), 32'h03);
    check("a_idle", 32'(bus.grant), 32'h0);
    step();
    check("a_sv_end", 32'(bus.send_valid), 32'h0);
    check("a_busy_end", 32'(bus.busy), 32'h0);
    ex = '{8'h01, 8'h02, 8'h03};
    cmp_rx("a_rx");

    // Two requesters from reset: req0 first, then req1.
    do_reset();
    add(0, 8'hA0, 1'b0); add(0, 8'hA1, 1'b1);
    add(1, 8'hB0, 1'b0); add(1, 8'hB1, 1'b1);
    run_until(4, "b_count");
    ex = '{8'hA0, 8'hA1, 8'hB0, 8'hB1};
    cmp_rx("b_rx");
    check("b_glog_n", 32'(glog.size()), 32'd2);
    check("b_g0", (glog.size() > 0) ? 32'(glog[0]) : 32'hDEAD, 32'h1);
    check("b_g1", (glog.size() > 1) ? 32'(glog[1]) : 32'hDEAD, 32'h2);

    // Burst cap of 4 forces release mid-packet.
    do_reset();
    for (int i = 0; i < 10; i++) add(0, 8'(8'h10 + i), (i == 9));
    add(1, 8'hB0, 1'b1);
    run_until(11, "c_count");
    ex = '{8'h10, 8'h11, 8'h12, 8'h13, 8'hB0, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19};
    cmp_rx("c_rx");
    check("c_glog_n", 32'(glog.size()), 32'd4);
    check("c_g1", (glog.size() > 1) ? 32'(glog[1]) : 32'hDEAD, 32'h2);
    check("c_g2", (glog.size() > 2) ? 32'(glog[2]) : 32'hDEAD, 32'h1);

    // Backpressure: 5A held for 5 stalled cycles.
    do_reset();
    add(0, 8'h5A, 1'b0); add(0, 8'h5B, 1'b1);
    sr = 1'b0;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("d_rdy%0d", i), 32'(rdy_seen), 32'h0);
      check($sformatf("d_sv%0d", i), 32'(bus.send_valid), 32'h1);
      check($sformatf("d_sd%0d", i), 32'(bus.send_data), 32'h5A);
    end
    sr = 1'b1;
    run_until(2, "d_count");
    ex = '{8'h5A, 8'h5B};
    cmp_rx("d_rx");

    // Link drop after 2 bytes: pending byte discarded, restart from IDLE.
    do_reset();
    add(0, 8'hC0, 1'b0); add(0, 8'hC1, 1'b0); add(0, 8'hC2, 1'b0); add(0, 8'hC3, 1'b1);
    step();
    step();
    step();
    link = 1'b0;
    sr   = 1'b0;
    step();
    check("e_rdy", 32'(rdy_seen), 32'h0);
    check("e_sv", 32'(bus.send_valid), 32'h0);
    check("e_grant", 32'(bus.grant), 32'h0);
    check("e_busy", 32'(bus.busy), 32'h0);
    step();
    check("e_rdy2", 32'(rdy_seen), 32'h0);
    check("e_grant2", 32'(bus.grant), 32'h0);
    link = 1'b1;
    sr   = 1'b1;
    step();
    check("e_regrant", 32'(bus.grant), 32'h1);
    check("e_sv_re", 32'(bus.send_valid), 32'h0);
    run_until(3, "e_count");
    ex = '{8'hC0, 8'hC2, 8'hC3};
    cmp_rx("e_rx");

    // Async reset mid-burst, then req0 wins first again.
    do_reset();
    add(0, 8'hD0, 1'b1);
    run_until(1, "f_pre");
    rx.delete();
    add(0, 8'hD1, 1'b0); add(0, 8'hD2, 1'b0); add(0, 8'hD3, 1'b1);
    step();
    step();
    check("f_mid_grant", 32'(bus.grant), 32'h1);
    check("f_mid_sv", 32'(bus.send_valid), 32'h1);
    rst = 1'b1;
    #1;
    check("f_rst_grant", 32'(bus.grant), 32'h0);
    check("f_rst_sv", 32'(bus.send_valid), 32'h0);
    check("f_rst_sd", 32'(bus.send_data), 32'h0);
    check("f_rst_busy", 32'(bus.busy), 32'h0);
    check("f_rst_rdy", 32'(bus.req_ready), 32'h0);
    q0.delete(); q1.delete(); rx.delete(); glog.delete();
    gprev = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    add(0, 8'hF0, 1'b1);
    add(1, 8'hE0, 1'b1);
    run_until(2, "f_count");
    ex = '{8'hF0, 8'hE0};
    cmp_rx("f_rx");
    check("f_g0", (glog.size() > 0) ? 32'(glog[0]) : 32'hDEAD, 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
